seq_array_multiplier: RTL
=========================

Name: seq_array_multiplier

Overview:
Parametrised sequential shift-add multiplier, successor to the fixed 6x6 combinational array multiplier. It computes one partial-product row per clock instead of a full array. It accepts an N-bit multiplicand and an M-bit multiplier through a valid/ready handshake and supports unsigned and two's-complement signed modes. It returns an (N+M)-bit product through a valid/ready output handshake and holds the result under backpressure.

Parameters:
N, 6, multiplicand (A) width, >= 2
M, 6, multiplier (B) width, >= 2; also the number of iteration cycles

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  N  multiplicand
B  input  M  multiplier
mode_signed  input  1  0 = unsigned x unsigned, 1 = signed x signed (two's complement)
out_valid  output  1  product S valid
out_ready  input  1  consumer accepts S
S  output  N+M  product
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States:
  - IDLE: in_ready=1.
  - RUN: iterating.
  - DONE: out_valid=1.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, S=0, iteration counter=0, accumulator=0. Reset wins over every other input in the same cycle, including mid-RUN and in DONE. Any in-flight result is discarded with no output.
- Accept: an edge with in_valid&&in_ready registers A, B and mode_signed, clears the accumulator and counter, and moves to RUN.
  - Operand changes after acceptance have no effect.
- RUN: one iteration per cycle, i = 0..M-1.
  - If B[i] is 1, add A, extended to N+1 bits, into the upper N+1 bits of the accumulator. Then shift the accumulator right by 1, bringing in the carry (unsigned) or the sign bit (signed).
  - Signed mode: A is sign-extended. At i = M-1 the row subtracts A instead of adding it, because the MSB of B carries negative weight.
  - Unsigned mode: A is zero-extended and all rows add.
- Accumulator width: N+M+1 bits internally. S is the low N+M bits; the result is exact, with no overflow possible.
- Latency: out_valid rises exactly M cycles after the accept edge (after the edge that completes i = M-1). The state moves to DONE on that edge.
- DONE:
  - S and out_valid are held stable until an edge with out_valid&&out_ready; that edge returns the state to IDLE and clears out_valid.
  - S keeps its last value after out_valid falls.
  - in_ready=0 in DONE: there is no accept in the same cycle as output handshake, so throughput is one product per M+2 cycles.
- in_valid asserted during RUN or DONE is ignored and not queued. The producer must hold in_valid until in_ready.
- B bits equal to 0 still consume a cycle; latency is data-independent.
- out_ready may be held high permanently; DONE then lasts exactly one cycle.
- Counter width is clog2(M) bits; terminal count is M-1, and there is no wrap beyond it.

Decomposition:
- Shared package seq_mult_pkg:
  - state enum {IDLE, RUN, DONE}.
  - function to compute the counter width clog2(M).
  - localparams for accumulator width N+M+1 and product width N+M.
- One natural sub-module, mult_row_addsub. It is a combinational (N+1)-bit adder/subtractor with inputs partial, addend and sub, and outputs sum and carry/sign. It is instanced once and reused each RUN cycle.
- FSM, counter and accumulator stay in the top module.

Test Plan:
1. Reset, then mode 0, A=10, B=11, out_ready=1 -> in_ready drops the cycle after accept; out_valid rises exactly 6 cycles after the accept edge; S=12'd110.
2. Mode 0, A=63, B=63 -> S=12'd3969 (12'hF81); then A=0, B=45 -> S=0, with the same 6-cycle latency.
3. Mode 1, A=6'h3F (-1), B=6'h3F (-1) -> S=12'h001; then A=6'h20 (-32), B=6'h1F (31) -> S=12'hC20 (-992).
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> S and out_valid stay constant; a new in_valid with A=5, B=5 is ignored. After out_ready=1: one handshake, then IDLE; the next accept gives S=25.
5. Reset mid-operation: assert rst at RUN iteration 3 of A=7, B=9 -> next cycle in_ready=1, out_valid=0, S=0, and no product is emitted. A fresh A=3, B=7 then gives S=21.
6. Parameter sweep N=8, M=4 and N=4, M=8 -> random operands in both modes match the reference model a*b. Latency equals M in every case.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_N      = 6;
    localparam int unsigned DEF_M      = 6;
    localparam int unsigned DEF_ACC_W  = DEF_N + DEF_M + 1;
    localparam int unsigned DEF_PROD_W = DEF_N + DEF_M;

    // Iteration counter width; a 1-bit floor keeps degenerate widths legal.
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned m);
        return n + m + 1;
    endfunction

    function automatic int unsigned prod_width(input int unsigned n, input int unsigned m);
        return n + m;
    endfunction

endpackage

// File: rtl/mult_row_addsub.sv
// One partial-product row: W-bit add or subtract returning the W-bit sum plus
// the bit shifted into the accumulator MSB (carry when unsigned, sign when signed).
module mult_row_addsub #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] partial_i,
    input  logic [W-1:0] addend_i,
    input  logic         sub_i,
    input  logic         signed_i,
    output logic [W-1:0] sum_o,
    output logic         cs_o
);

    localparam int unsigned XW = W + 1;

    logic [XW-1:0] p_ext;
    logic [XW-1:0] a_ext;
    logic [XW-1:0] res;

    // One extra bit makes the top of the result the true carry or sign.
    always_comb begin
        p_ext = {signed_i & partial_i[W-1], partial_i};
        a_ext = {signed_i & addend_i[W-1], addend_i};
        res   = sub_i ? (p_ext - a_ext) : (p_ext + a_ext);
    end

    assign sum_o = res[W-1:0];
    assign cs_o  = res[XW-1];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per clock, unsigned
// or two's-complement, valid/ready on both sides, result held under backpressure.
module seq_array_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned M = DEF_M
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        A,
    input  logic [M-1:0]        B,
    input  logic                mode_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N+M-1:0]      S,
    output logic                busy
);

    localparam int unsigned ACC_W  = acc_width(N, M);
    localparam int unsigned PROD_W = prod_width(N, M);
    localparam int unsigned CW     = cnt_width(M);
    localparam int unsigned RW     = N + 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [N-1:0]        a_q, a_d;
    logic [M-1:0]        b_q, b_d;
    logic                sgn_q, sgn_d;
    logic [PROD_W-1:0]   s_q, s_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [RW-1:0]       row_addend;
    logic [RW-1:0]       row_sum;
    logic                row_cs;
    logic                row_sub;
    logic                last_iter;
    logic [ACC_W-1:0]    acc_next;
    logic                unused_acc_lsb;

    assign last_iter  = (cnt_q == CW'(M - 1));
    // The multiplier MSB has negative weight in signed mode.
    assign row_sub    = sgn_q & last_iter;
    assign row_addend = b_q[cnt_q] ? {sgn_q & a_q[N-1], a_q} : '0;

    mult_row_addsub #(
        .W (RW)
    ) u_row (
        .partial_i (acc_q[ACC_W-1 -: RW]),
        .addend_i  (row_addend),
        .sub_i     (row_sub),
        .signed_i  (sgn_q),
        .sum_o     (row_sum),
        .cs_o      (row_cs)
    );

    // Add into the upper bits, then shift right by one with carry/sign fill.
    assign acc_next       = {row_cs, row_sum, acc_q[M-1:1]};
    assign unused_acc_lsb = acc_q[0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        s_d         = s_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = mode_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                if (last_iter) begin
                    s_d     = acc_next[PROD_W-1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign S         = s_q;

endmodule
